// File: rtl/testchip_testclk_ctrl.sv
// Glitch-free test-clock select/gate sequencer: gate off, switch, settle, gate on.
// Optional acknowledge timeout enabled by defining TESTCLK_CTRL_TIMEOUT_EN.
module testchip_testclk_ctrl #(
    parameter int SETTLE_CYCLES = 16,
    parameter int ACK_TIMEOUT   = 255
) (
    input  logic       uc_clk,
    input  logic       reset_n,
    input  logic       req_valid,
    input  logic [3:0] req_sel,
    input  logic       req_en,
    output logic       req_ready,
    input  logic       en_ack,
    output logic [3:0] test_clk_sel,
    output logic       test_clk_en,
    output logic       busy,
    output logic       done,
    output logic       ack_timeout
);
    typedef enum logic [2:0] {IDLE, GATE_OFF, SWITCH, GATE_ON, DONE} state_t;

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..255");
    end
    if (ACK_TIMEOUT < 4 || ACK_TIMEOUT > 255) begin : g_bad_timeout
        $error("ACK_TIMEOUT must be in 4..255");
    end

    state_t     r_state;
    state_t     w_next;
    logic       r_ack_s1;
    logic       r_ack_s2;
    logic [3:0] r_sel;
    logic       r_en;
    logic [3:0] r_lat_sel;
    logic       r_lat_en;
    logic [7:0] r_settle;
    logic       w_accept;
    logic       w_enter_switch;
    logic [3:0] w_sel_src;
    logic       w_tmo;

    assign w_accept       = (r_state == IDLE) && req_valid;
    assign w_enter_switch = (w_next == SWITCH) && (r_state != SWITCH);
    // IDLE can jump straight to SWITCH before the request has been latched
    assign w_sel_src      = (r_state == IDLE) ? req_sel : r_lat_sel;

    always_ff @(posedge uc_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ack_s1 <= 1'b0;
            r_ack_s2 <= 1'b0;
        end else begin
            r_ack_s1 <= en_ack;
            r_ack_s2 <= r_ack_s1;
        end
    end

`ifdef TESTCLK_CTRL_TIMEOUT_EN
    logic [7:0] r_wait;
    logic       r_tmo;

    assign w_tmo = ((r_state == GATE_OFF) || (r_state == GATE_ON)) &&
                   (r_wait == 8'(ACK_TIMEOUT - 1));

    always_ff @(posedge uc_clk) begin
        if (w_next != r_state) begin
            r_wait <= 8'd0;
        end else if (r_wait != 8'hFF) begin
            r_wait <= r_wait + 8'd1;
        end
    end

    always_ff @(posedge uc_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo <= 1'b0;
        end else if (w_accept) begin
            r_tmo <= 1'b0;
        end else if (w_tmo) begin
            r_tmo <= 1'b1;
        end
    end

    assign ack_timeout = r_tmo;
`else
    assign w_tmo       = 1'b0;
    assign ack_timeout = 1'b0;
`endif

    always_ff @(posedge uc_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if ((req_sel == r_sel) && (req_en == r_en)) begin
                        w_next = DONE;
                    end else if (!r_en) begin
                        w_next = SWITCH;
                    end else begin
                        w_next = GATE_OFF;
                    end
                end
            end
            GATE_OFF: if (!r_ack_s2 || w_tmo) w_next = SWITCH;
            SWITCH:   if (r_settle == 8'd0) w_next = r_lat_en ? GATE_ON : DONE;
            GATE_ON:  if (r_ack_s2 || w_tmo) w_next = DONE;
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge uc_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel <= 4'b0000;
            r_en  <= 1'b0;
        end else begin
            if (w_enter_switch) begin
                r_sel <= w_sel_src;
            end
            // gate closes on the accept edge; it reopens only once settling is over
            if ((r_state == IDLE) && (w_next == GATE_OFF)) begin
                r_en <= 1'b0;
            end else if (r_state == GATE_ON) begin
                r_en <= 1'b1;
            end
        end
    end

    always_ff @(posedge uc_clk) begin
        if (w_accept) begin
            r_lat_sel <= req_sel;
            r_lat_en  <= req_en;
        end
        if (w_enter_switch) begin
            r_settle <= 8'(SETTLE_CYCLES - 1);
        end else if ((r_state == SWITCH) && (r_settle != 8'd0)) begin
            r_settle <= r_settle - 8'd1;
        end
    end

    assign test_clk_sel = r_sel;
    assign test_clk_en  = r_en;
    assign req_ready    = (r_state == IDLE);
    assign busy         = (r_state != IDLE);
    assign done         = (r_state == DONE);

endmodule

// File: tb/tb_testchip_testclk_ctrl.sv
// Bench for testchip_testclk_ctrl: gating cell modelled as a 3-cycle echo of the gate enable.
// Timing expectations come from an edge-count model of the request sequence.
`timescale 1ns/1ps
module tb_testchip_testclk_ctrl;
    localparam int S = 16;

    logic       uc_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [3:0] req_sel = 4'd0;
    logic       req_en = 1'b0;
    logic       req_ready;
    logic       en_ack;
    logic [3:0] test_clk_sel;
    logic       test_clk_en;
    logic       busy;
    logic       done;
    logic       ack_timeout;

    logic [2:0] hist = 3'b000;
    logic       stuck = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [3:0] m_sel = 4'd0;
    logic       m_en = 1'b0;

    testchip_testclk_ctrl #(.SETTLE_CYCLES(S), .ACK_TIMEOUT(255)) dut (
        .uc_clk(uc_clk), .reset_n(reset_n), .req_valid(req_valid), .req_sel(req_sel),
        .req_en(req_en), .req_ready(req_ready), .en_ack(en_ack), .test_clk_sel(test_clk_sel),
        .test_clk_en(test_clk_en), .busy(busy), .done(done), .ack_timeout(ack_timeout)
    );

    always #5 uc_clk = ~uc_clk;
    always @(posedge uc_clk) hist <= {hist[1:0], test_clk_en};
    assign en_ack = stuck ? 1'b1 : hist[2];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Edge offsets (relative to the accept edge) at which events are expected.
    function automatic int exp_done(input logic [3:0] cs, input logic ce, input logic [3:0] s, input logic e);
        if (s == cs && e == ce) return 0;
        return (ce ? 6 : 0) + S + (e ? 7 : 0);
    endfunction
    function automatic int exp_sel(input logic [3:0] cs, input logic ce, input logic [3:0] s);
        if (s == cs) return -1;
        return ce ? 6 : 0;
    endfunction
    function automatic int exp_rise(input logic [3:0] cs, input logic ce, input logic [3:0] s, input logic e);
        if ((s == cs && e == ce) || !e) return -1;
        return (ce ? 6 : 0) + S + 1;
    endfunction
    function automatic int exp_fall(input logic [3:0] cs, input logic ce, input logic [3:0] s, input logic e);
        if ((s == cs && e == ce) || !ce) return -1;
        return 0;
    endfunction

    task automatic run_req(input logic [3:0] s, input logic e, output int t_sel, output int t_rise,
                           output int t_fall, output int t_done, output int n_done, output int n_bad);
        logic [3:0] psel;
        logic       pen;
        logic       a1, a2, a3;
        t_sel = -1; t_rise = -1; t_fall = -1; t_done = -1; n_done = 0; n_bad = 0;
        @(negedge uc_clk);
        psel = test_clk_sel; pen = test_clk_en;
        a1 = en_ack; a2 = en_ack; a3 = en_ack;
        req_sel = s; req_en = e; req_valid = 1'b1;
        for (int k = 0; k < 700; k++) begin
            @(posedge uc_clk); #1;
            if (k == 0) req_valid = 1'b0;
            if (test_clk_sel !== psel) begin
                if (t_sel < 0) t_sel = k;
                if (pen || a3) n_bad++;
            end
            if (!pen && test_clk_en) if (t_rise < 0) t_rise = k;
            if (pen && !test_clk_en) if (t_fall < 0) t_fall = k;
            if (done) begin
                n_done++;
                if (t_done < 0) t_done = k;
            end
            psel = test_clk_sel; pen = test_clk_en;
            a3 = a2; a2 = a1; a1 = en_ack;
            if (t_done >= 0 && k >= t_done + 3) break;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge uc_clk);
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_held: got %b want 0", busy); end
        @(negedge uc_clk); reset_n = 1'b1;
        repeat (2) @(posedge uc_clk);
        #1;
        n_tests++; if (test_clk_sel !== 4'd0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", test_clk_sel); end
        n_tests++; if (test_clk_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b want 0", test_clk_en); end
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++; if (ack_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_tmo: got %b want 0", ack_timeout); end
        m_sel = 4'd0; m_en = 1'b0;
    endtask

    task automatic test_first_enable();
        int ts, tr, tf, td, nd, nb;
        run_req(4'd2, 1'b1, ts, tr, tf, td, nd, nb);
        n_tests++; if (ts !== 0) begin n_fail++; $display("FAIL first_sel_edge: got %0d want 0", ts); end
        n_tests++; if (tr - ts !== S + 1) begin n_fail++; $display("FAIL first_sel_to_en: got %0d want %0d", tr - ts, S + 1); end
        n_tests++; if (td !== exp_done(m_sel, m_en, 4'd2, 1'b1)) begin n_fail++; $display("FAIL first_done_edge: got %0d want %0d", td, exp_done(m_sel, m_en, 4'd2, 1'b1)); end
        n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL first_done_count: got %0d want 1", nd); end
        n_tests++; if (ack_timeout !== 1'b0) begin n_fail++; $display("FAIL first_tmo: got %b want 0", ack_timeout); end
        n_tests++; if ({test_clk_sel, test_clk_en} !== {4'd2, 1'b1}) begin n_fail++; $display("FAIL first_final: got sel %0d en %b want sel 2 en 1", test_clk_sel, test_clk_en); end
        m_sel = 4'd2; m_en = 1'b1;
    endtask

    task automatic test_switch();
        int ts, tr, tf, td, nd, nb;
        run_req(4'd6, 1'b1, ts, tr, tf, td, nd, nb);
        n_tests++; if (tf !== 0) begin n_fail++; $display("FAIL switch_en_fall: got %0d want 0", tf); end
        n_tests++; if (ts !== exp_sel(m_sel, m_en, 4'd6)) begin n_fail++; $display("FAIL switch_sel_edge: got %0d want %0d", ts, exp_sel(m_sel, m_en, 4'd6)); end
        n_tests++; if (tr !== exp_rise(m_sel, m_en, 4'd6, 1'b1)) begin n_fail++; $display("FAIL switch_en_rise: got %0d want %0d", tr, exp_rise(m_sel, m_en, 4'd6, 1'b1)); end
        n_tests++; if (nb !== 0) begin n_fail++; $display("FAIL switch_sel_unsafe: got %0d want 0", nb); end
        n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL switch_done_count: got %0d want 1", nd); end
        n_tests++; if ({test_clk_sel, test_clk_en} !== {4'd6, 1'b1}) begin n_fail++; $display("FAIL switch_final: got sel %0d en %b want sel 6 en 1", test_clk_sel, test_clk_en); end
        m_sel = 4'd6; m_en = 1'b1;
    endtask

    task automatic test_noop();
        int ts, tr, tf, td, nd, nb;
        run_req(4'd6, 1'b1, ts, tr, tf, td, nd, nb);
        n_tests++; if (td !== 0) begin n_fail++; $display("FAIL noop_done_edge: got %0d want 0", td); end
        n_tests++; if ({ts, tr, tf} !== {-32'sd1, -32'sd1, -32'sd1}) begin n_fail++; $display("FAIL noop_toggle: got sel %0d rise %0d fall %0d want -1 -1 -1", ts, tr, tf); end
        n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL noop_done_count: got %0d want 1", nd); end
    endtask

    task automatic test_random();
        int ts, tr, tf, td, nd, nb;
        logic [3:0] s;
        logic       e;
        for (int i = 0; i < 16; i++) begin
            s = ($urandom_range(0, 3) == 0) ? m_sel : 4'($urandom_range(0, 15));
            e = ($urandom_range(0, 3) == 0) ? m_en : 1'($urandom_range(0, 1));
            run_req(s, e, ts, tr, tf, td, nd, nb);
            n_tests++; if (td !== exp_done(m_sel, m_en, s, e)) begin n_fail++; $display("FAIL rand%0d_done_edge: got %0d want %0d", i, td, exp_done(m_sel, m_en, s, e)); end
            n_tests++; if (ts !== exp_sel(m_sel, m_en, s)) begin n_fail++; $display("FAIL rand%0d_sel_edge: got %0d want %0d", i, ts, exp_sel(m_sel, m_en, s)); end
            n_tests++; if ({tr, tf} !== {exp_rise(m_sel, m_en, s, e), exp_fall(m_sel, m_en, s, e)}) begin n_fail++; $display("FAIL rand%0d_en_edges: got rise %0d fall %0d want %0d %0d", i, tr, tf, exp_rise(m_sel, m_en, s, e), exp_fall(m_sel, m_en, s, e)); end
            n_tests++; if ({nd, nb} !== {32'sd1, 32'sd0}) begin n_fail++; $display("FAIL rand%0d_done_unsafe: got done %0d unsafe %0d want 1 0", i, nd, nb); end
            n_tests++; if ({test_clk_sel, test_clk_en, ack_timeout} !== {s, e, 1'b0}) begin n_fail++; $display("FAIL rand%0d_final: got sel %0d en %b tmo %b want sel %0d en %b tmo 0", i, test_clk_sel, test_clk_en, ack_timeout, s, e); end
            m_sel = s; m_en = e;
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] s;
        s = (m_sel == 4'd9) ? 4'd10 : 4'd9;
        @(negedge uc_clk);
        req_sel = s; req_en = 1'b1; req_valid = 1'b1;
        @(posedge uc_clk); #1;
        req_valid = 1'b0;
        repeat ((m_en ? 6 : 0) + 3) @(posedge uc_clk);
        #1;
        n_tests++; if ({busy, test_clk_sel, test_clk_en} !== {1'b1, s, 1'b0}) begin n_fail++; $display("FAIL mid_switch_state: got busy %b sel %0d en %b want 1 %0d 0", busy, test_clk_sel, test_clk_en, s); end
        @(negedge uc_clk);
        reset_n = 1'b0;
        #1;
        n_tests++; if ({test_clk_sel, test_clk_en, req_ready, busy, done, ack_timeout} !== {4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got sel %0d en %b rdy %b busy %b done %b tmo %b want 0 0 1 0 0 0", test_clk_sel, test_clk_en, req_ready, busy, done, ack_timeout);
        end
        repeat (2) @(negedge uc_clk);
        reset_n = 1'b1;
        repeat (S + 10) begin
            @(posedge uc_clk); #1;
            n_tests++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_after_reset: got done %b busy %b want 0 0", done, busy); end
        end
        m_sel = 4'd0; m_en = 1'b0;
    endtask

    task automatic test_busy_ignore();
        int nd = 0;
        int td = -1;
        @(negedge uc_clk);
        req_sel = 4'd5; req_en = 1'b1; req_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(posedge uc_clk); #1;
            if (k == 0) req_valid = 1'b0;
            if (k == 4) begin
                n_tests++; if ({busy, req_ready} !== 2'b10) begin n_fail++; $display("FAIL busy_flags: got busy %b rdy %b want 1 0", busy, req_ready); end
                req_sel = 4'hA; req_en = 1'b0; req_valid = 1'b1;
            end
            if (k == 5) req_valid = 1'b0;
            if (done) begin nd++; if (td < 0) td = k; end
            if (td >= 0 && k >= td + 6) break;
        end
        n_tests++; if (td !== exp_done(m_sel, m_en, 4'd5, 1'b1)) begin n_fail++; $display("FAIL busy_done_edge: got %0d want %0d", td, exp_done(m_sel, m_en, 4'd5, 1'b1)); end
        n_tests++; if (nd !== 1) begin n_fail++; $display("FAIL busy_done_count: got %0d want 1", nd); end
        n_tests++; if ({test_clk_sel, test_clk_en} !== {4'd5, 1'b1}) begin n_fail++; $display("FAIL busy_final: got sel %0d en %b want 5 1", test_clk_sel, test_clk_en); end
        m_sel = 4'd5; m_en = 1'b1;
    endtask

`ifdef TESTCLK_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int ts, tr, tf, td, nd, nb;
        stuck = 1'b1;
        run_req(4'd8, 1'b1, ts, tr, tf, td, nd, nb);
        n_tests++; if (ts !== 255) begin n_fail++; $display("FAIL tmo_sel_edge: got %0d want 255", ts); end
        n_tests++; if (td !== 256 + S) begin n_fail++; $display("FAIL tmo_done_edge: got %0d want %0d", td, 256 + S); end
        n_tests++; if ({ack_timeout, test_clk_sel, test_clk_en} !== {1'b1, 4'd8, 1'b1}) begin n_fail++; $display("FAIL tmo_final: got tmo %b sel %0d en %b want 1 8 1", ack_timeout, test_clk_sel, test_clk_en); end
        stuck = 1'b0;
        repeat (5) @(posedge uc_clk);
        run_req(4'd3, 1'b1, ts, tr, tf, td, nd, nb);
        n_tests++; if (ack_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_cleared: got %b want 0", ack_timeout); end
        n_tests++; if (td !== exp_done(4'd8, 1'b1, 4'd3, 1'b1)) begin n_fail++; $display("FAIL tmo_next_done: got %0d want %0d", td, exp_done(4'd8, 1'b1, 4'd3, 1'b1)); end
        m_sel = 4'd3; m_en = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_first_enable();
        test_switch();
        test_noop();
        test_random();
        test_reset_mid();
        test_busy_ignore();
`ifdef TESTCLK_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/testchip_testclk_ctrl.md
# testchip_testclk_ctrl

Sequencer for the test-chip test-clock observation path. It accepts select/enable requests from the microcontroller and drives the select and gate-enable of the test-clock mux and gating cell. Every source change follows a glitch-free order: gate off, wait for acknowledge, switch, settle, gate on, wait for acknowledge. It runs in the `uc_clk` domain beside the test-clock mux in the test chip.

## Interface
- `SETTLE_CYCLES`, default 16: `uc_clk` cycles held after a select change before re-enable; legal range 1..255.
- `ACK_TIMEOUT`, default 255: maximum `uc_clk` cycles to wait for the gating acknowledge; legal range 4..255.
- `uc_clk`  in  1  controller clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request strobe.
- `req_sel`  in  4  requested mux select code.
- `req_en`  in  1  requested gate state after the switch.
- `req_ready`  out  1  high in IDLE only.
- `en_ack`  in  1  gating-cell acknowledge; asynchronous to `uc_clk`, synchronized internally by 2 flops.
- `test_clk_sel`  out  4  registered mux select.
- `test_clk_en`  out  1  registered gate enable.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse when a request completes.
- `ack_timeout`  out  1  sticky error flag; cleared by the next accepted request.

## Operation
- States: IDLE, GATE_OFF, SWITCH, GATE_ON, DONE.
- IDLE:
  - `req_ready`=1.
  - `req_valid`&`req_ready` latches `req_sel`/`req_en` and clears `ack_timeout`.
  - If `req_sel`==`test_clk_sel` and `req_en`==`test_clk_en`, go straight to DONE (no-op path).
  - Else if `test_clk_en`=0, go to SWITCH.
  - Else go to GATE_OFF.
- GATE_OFF:
  - `test_clk_en`←0.
  - Wait for synced `en_ack`=0, then go to SWITCH.
- SWITCH:
  - On entry, `test_clk_sel`←latched select and the settle counter is loaded with `SETTLE_CYCLES`-1.
  - Decrement each cycle. At 0: go to GATE_ON if latched `req_en`=1, else DONE.
  - If the select is unchanged (enable-only request), the settle count still runs.
- GATE_ON:
  - `test_clk_en`←1.
  - Wait for synced `en_ack`=1, then go to DONE.
- DONE:
  - `done`=1 for one cycle, then IDLE.
- Timeout (when compiled in):
  - An 8-bit wait counter runs in GATE_OFF and GATE_ON and is cleared on every state entry.
  - Reaching `ACK_TIMEOUT` sets `ack_timeout`.
  - In GATE_OFF the FSM proceeds to SWITCH anyway. A dead source clock cannot acknowledge, and the gate output is already low because the cell is clockless.
  - In GATE_ON the FSM proceeds to DONE with `test_clk_en` left at 1.
- `req_valid` outside IDLE is ignored; there is no queueing.
- `req_sel[3]`=1 selects the PHY test clock regardless of `req_sel[2:0]`. The controller still compares and forwards all 4 bits.

## Timing
- Reset values: `test_clk_sel`=4'b0000, `test_clk_en`=0, `req_ready`=1, `busy`=0, `done`=0, `ack_timeout`=0, state IDLE, synchronizer flops 0.
- Reset is asynchronous assert and synchronous deassert by use. Reset mid-sequence returns to IDLE immediately with the outputs above, so the gate closes.
- Request accepted at edge N:
  - `busy`=1 and `req_ready`=0 from N+1.
  - In GATE_OFF, `test_clk_en` falls at N+1.
- `en_ack` synchronization adds 2 cycles of latency to every acknowledge.
- Minimum full sequence with gate previously on: 1 (GATE_OFF entry) + 2 (sync) + `SETTLE_CYCLES` + 1 + 2 + 1 (DONE).
- No-op request: `done` at N+1, back in IDLE at N+2.
- `test_clk_sel` changes only in the SWITCH entry cycle, never while `test_clk_en`=1 or while synced `en_ack`=1 (except after a timeout in GATE_OFF).

## Configuration
- `TESTCLK_CTRL_TIMEOUT_EN` defined: the wait counter and `ack_timeout` logic are present, as described above.
- `TESTCLK_CTRL_TIMEOUT_EN` undefined: GATE_OFF and GATE_ON wait indefinitely for the acknowledge, and `ack_timeout` is tied to 0.

## Test plan
- Reset, then request sel=4'b0010, en=1, with `en_ack` mirroring `test_clk_en` after 3 `uc_clk` cycles. Required: `test_clk_sel`=2 exactly `SETTLE_CYCLES`+1 cycles before `test_clk_en`=1; `done` pulses once; no `ack_timeout`.
- With sel=2 enabled, request sel=4'b0110, en=1. Required: `test_clk_en` drops first; `test_clk_sel` changes only after synced `en_ack`=0; gate re-enables; `test_clk_sel` is stable whenever `en_ack`=1.
- Request identical to current state (sel=6, en=1). Required: `done` at N+1, and `test_clk_sel`/`test_clk_en` never toggle.
- Timeout, with macro defined: hold `en_ack`=1 stuck and request sel=4'b1000. Required: `ack_timeout`=1 after 255 cycles in GATE_OFF; select becomes 8; sequence completes. The next accepted request clears the flag.
- Assert `reset_n` low mid-SWITCH, and drive `req_valid` while `busy`=1. Required: all outputs take reset values immediately; the mid-sequence request is ignored with no second `done`.
